// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// S/Cout are registered and update only when the last bit has been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
    logic             carry, s_bit, carry_next, last_bit;
    logic [CW-1:0]    cnt;

    assign s_bit      = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign sum_next   = (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= A;
                    b_sh   <= B;
                    carry  <= Cin;
                    sum_sh <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= carry_next;
                    sum_sh <= sum_next;
                    cnt    <= cnt + CW'(1);
                    // Publish only the complete result so S never shows partial sums.
                    if (last_bit) begin
                        S    <= sum_next;
                        Cout <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
